core_mem_responder: RTL and testbench

- Memory-side responder for the multicycle core's instruction-fetch and load/store requests.
- Owns a single-port word-organised RAM. Two request channels (fetch, data) use valid/ready handshakes.
- Fixed-priority arbitration; one outstanding access at a time. Each response is held until the core accepts it.
- Sits between the core's fetch/execute stages and on-chip block RAM.

---
 rtl/core_mem_responder.sv | 176 +++++++++++++++++
 tb/tb_core_mem_responder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_responder.sv
// Memory-side responder: arbitrates fetch/data requests onto one word RAM.
// Optional misaligned-access error reporting is enabled by MEM_MISALIGN_CHECK_EN.
module core_mem_responder #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_req_addr,
  output logic        i_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] i_resp_data,
  output logic        i_resp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_req_addr,
  input  logic        d_req_we,
  input  logic [3:0]  d_req_wstrb,
  input  logic [31:0] d_req_wdata,
  output logic        d_resp_valid,
  input  logic        d_resp_ready,
  output logic [31:0] d_resp_data,
  output logic        d_resp_err,
  output logic [1:0]  fsm_state
);

  // Handshakes: a request transfers on a posedge where valid && ready are both 1;
  // a response is held (valid, data, err stable) until the posedge where ready is 1.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                  sel_d_q;
  logic [31:0]           addr_q;
  logic                  we_q;
  logic [3:0]            wstrb_q;
  logic [31:0]           wdata_q;
  logic [31:0]           mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic                  misalign;
  logic                  accept_d;
  logic                  accept_i;
  logic                  resp_hs;
  logic                  i_valid_q, d_valid_q;
  logic [31:0]           i_data_q, d_data_q;
  logic                  unused_ok;

  // Upper address bits wrap; byte offset only matters for the misalign check.
  assign idx       = addr_q[ADDR_WIDTH+1:2];
  assign unused_ok = ^{addr_q[31:ADDR_WIDTH+2], addr_q[1:0]};
  assign fsm_state = state_q;

  always_ff @(posedge clk) begin
    if (rstn) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    d_req_ready = 1'b0;
    i_req_ready = 1'b0;
    accept_d    = 1'b0;
    accept_i    = 1'b0;
    resp_hs     = 1'b0;
    case (state_q)
      IDLE: begin
        d_req_ready = 1'b1;
        i_req_ready = !d_req_valid;
        accept_d    = d_req_valid;
        accept_i    = i_req_valid && !d_req_valid;
        if (d_req_valid || i_req_valid) state_d = ACCESS;
      end
      ACCESS: state_d = RESP;
      RESP: begin
        resp_hs = sel_d_q ? d_resp_ready : i_resp_ready;
        if (resp_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture; fetches are recorded as full-word reads.
  always_ff @(posedge clk) begin
    if (rstn) begin
      sel_d_q <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wstrb_q <= '0;
      wdata_q <= '0;
    end else if (accept_d) begin
      sel_d_q <= 1'b1;
      addr_q  <= d_req_addr;
      we_q    <= d_req_we;
      wstrb_q <= d_req_wstrb;
      wdata_q <= d_req_wdata;
    end else if (accept_i) begin
      sel_d_q <= 1'b0;
      addr_q  <= i_req_addr;
      we_q    <= 1'b0;
      wstrb_q <= '0;
      wdata_q <= '0;
    end
  end

  // Byte-enabled store; reset in the same cycle cancels it.
  always_ff @(posedge clk) begin
    if (!rstn && state_q == ACCESS && we_q && !misalign) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      i_data_q  <= '0;
      d_data_q  <= '0;
    end else begin
      case (state_q)
        ACCESS: begin
          if (sel_d_q) begin
            d_valid_q <= 1'b1;
            d_data_q  <= (we_q || misalign) ? 32'h0 : mem[idx];
          end else begin
            i_valid_q <= 1'b1;
            i_data_q  <= misalign ? 32'h0 : mem[idx];
          end
        end
        RESP: begin
          if (resp_hs) begin
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign i_resp_valid = i_valid_q;
  assign d_resp_valid = d_valid_q;
  assign i_resp_data  = i_data_q;
  assign d_resp_data  = d_data_q;

`ifdef MEM_MISALIGN_CHECK_EN
  logic i_err_q, d_err_q;

  assign misalign = |addr_q[1:0];

  always_ff @(posedge clk) begin
    if (rstn) begin
      i_err_q <= 1'b0;
      d_err_q <= 1'b0;
    end else if (state_q == ACCESS) begin
      if (sel_d_q) d_err_q <= misalign;
      else         i_err_q <= misalign;
    end
  end

  assign i_resp_err = i_err_q;
  assign d_resp_err = d_err_q;
`else
  assign misalign   = 1'b0;
  assign i_resp_err = 1'b0;
  assign d_resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_core_mem_responder.sv
// Scoreboard bench for core_mem_responder: directed stores/loads/fetches,
// arbitration, back-pressure, aliasing, reset mid-access and misalignment.
module tb_core_mem_responder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_req_valid, i_req_ready;
  logic [31:0] i_req_addr;
  logic        i_resp_valid, i_resp_ready;
  logic [31:0] i_resp_data;
  logic        i_resp_err;
  logic        d_req_valid, d_req_ready;
  logic [31:0] d_req_addr;
  logic        d_req_we;
  logic [3:0]  d_req_wstrb;
  logic [31:0] d_req_wdata;
  logic        d_resp_valid, d_resp_ready;
  logic [31:0] d_resp_data;
  logic        d_resp_err;
  logic [1:0]  fsm_state;

  logic [32:0] exp_d_q[$];
  logic [32:0] exp_i_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int d_hs_edge = 0;

  core_mem_responder #(.ADDR_WIDTH(12)) dut (
    .clk(clk), .rstn(rstn),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_ready(i_resp_ready),
    .i_resp_data(i_resp_data), .i_resp_err(i_resp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wstrb(d_req_wstrb), .d_req_wdata(d_req_wdata),
    .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready),
    .d_resp_data(d_resp_data), .d_resp_err(d_resp_err),
    .fsm_state(fsm_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected queue on every response handshake
  always @(negedge clk) begin
    if (rstn === 1'b0) begin
      if (d_resp_valid || i_resp_valid)
        check("no_overlap", 32'(d_resp_valid & i_resp_valid), 32'h0);
      if (d_resp_valid && d_resp_ready) begin
        d_hs_edge = cyc + 1;
        if (exp_d_q.size() == 0) check("d_unexpected_resp", 32'h1, 32'h0);
        else begin
          logic [32:0] e;
          e = exp_d_q.pop_front();
          check("d_resp_data", d_resp_data, e[31:0]);
          check("d_resp_err", 32'(d_resp_err), 32'(e[32]));
        end
      end
      if (i_resp_valid && i_resp_ready) begin
        if (exp_i_q.size() == 0) check("i_unexpected_resp", 32'h1, 32'h0);
        else begin
          logic [32:0] e;
          e = exp_i_q.pop_front();
          check("i_resp_data", i_resp_data, e[31:0]);
          check("i_resp_err", 32'(i_resp_err), 32'(e[32]));
        end
      end
    end
  end

  // Driver: present a request, wait for acceptance, drop valid after the accepting edge
  task automatic send(input bit is_d, input logic [31:0] addr, input logic we,
                      input logic [3:0] wstrb, input logic [31:0] wdata, input logic [32:0] exp);
    int n;
    if (is_d) begin
      exp_d_q.push_back(exp);
      d_req_valid = 1'b1; d_req_addr = addr; d_req_we = we;
      d_req_wstrb = wstrb; d_req_wdata = wdata;
    end else begin
      exp_i_q.push_back(exp);
      i_req_valid = 1'b1; i_req_addr = addr;
    end
    n = 0;
    @(negedge clk);
    while (!(is_d ? d_req_ready : i_req_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("accept_timeout", 32'h1, 32'h0);
    @(posedge clk); #1;
    if (is_d) d_req_valid = 1'b0;
    else      i_req_valid = 1'b0;
  endtask

  // Called right after the accepting edge N: response must be seen at edge N+2
  task automatic chk_latency(input bit is_d);
    @(negedge clk);
    check("valid_at_n1", 32'(is_d ? d_resp_valid : i_resp_valid), 32'h0);
    check("readies_access", 32'({d_req_ready, i_req_ready}), 32'h0);
    @(negedge clk);
    check("valid_at_n2", 32'(is_d ? d_resp_valid : i_resp_valid), 32'h1);
    check("readies_resp", 32'({d_req_ready, i_req_ready}), 32'h0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_d_q.size() != 0 || exp_i_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      check("drain_timeout", 32'h1, 32'h0);
      exp_d_q.delete();
      exp_i_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    check({tag, "_d_valid"}, 32'(d_resp_valid), 32'h0);
    check({tag, "_i_valid"}, 32'(i_resp_valid), 32'h0);
    check({tag, "_d_data"}, d_resp_data, 32'h0);
    check({tag, "_i_data"}, i_resp_data, 32'h0);
    check({tag, "_errs"}, 32'({d_resp_err, i_resp_err}), 32'h0);
    check({tag, "_state"}, 32'(fsm_state), 32'h0);
  endtask

  initial begin
    int n;
    rstn = 1'b1;
    i_req_valid = 1'b0; i_req_addr = '0; i_resp_ready = 1'b1;
    d_req_valid = 1'b0; d_req_addr = '0; d_req_we = 1'b0;
    d_req_wstrb = '0; d_req_wdata = '0; d_resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);
    chk_outputs_zero("reset");
    check("idle_readies", 32'({d_req_ready, i_req_ready}), 32'h3);
    @(posedge clk); #1;

    // Full-word store then fetch, both with latency checks
    send(1'b1, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, {1'b0, 32'h0});
    chk_latency(1'b1);
    drain();
    send(1'b0, 32'h10, 1'b0, 4'h0, 32'h0, {1'b0, 32'hDEADBEEF});
    chk_latency(1'b0);
    drain();

    // Partial store: only byte 1 changes
    send(1'b1, 32'h10, 1'b1, 4'b0010, 32'h11223344, {1'b0, 32'h0});
    drain();
    send(1'b1, 32'h10, 1'b0, 4'h0, 32'h0, {1'b0, 32'hDEAD33EF});
    drain();

    // Both channels valid: data first, fetch one cycle after the data handshake
    exp_d_q.push_back({1'b0, 32'hDEAD33EF});
    exp_i_q.push_back({1'b0, 32'hDEAD33EF});
    i_req_valid = 1'b1; i_req_addr = 32'h10;
    d_req_valid = 1'b1; d_req_addr = 32'h10; d_req_we = 1'b0; d_req_wstrb = 4'h0;
    @(negedge clk);
    check("prio_d_ready", 32'(d_req_ready), 32'h1);
    check("prio_i_ready", 32'(i_req_ready), 32'h0);
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!i_req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("fetch_accept_edge", 32'(cyc + 1), 32'(d_hs_edge + 1));
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    drain();

    // Back-pressure: response held for 5 cycles, new request waits
    d_resp_ready = 1'b0;
    send(1'b1, 32'h10, 1'b0, 4'h0, 32'h0, {1'b0, 32'hDEAD33EF});
    chk_latency(1'b1);
    exp_d_q.push_back({1'b0, 32'hDEAD33EF});
    d_req_valid = 1'b1; d_req_addr = 32'h10; d_req_we = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", 32'(d_resp_valid), 32'h1);
      check("stall_data", d_resp_data, 32'hDEAD33EF);
      check("stall_readies", 32'({d_req_ready, i_req_ready}), 32'h0);
    end
    @(posedge clk); #1;
    d_resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ready_after_hs", 32'(d_req_ready), 32'h1);
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    chk_latency(1'b1);
    drain();

    // Aliasing above the RAM depth
    send(1'b1, 32'h4010, 1'b1, 4'hF, 32'hCAFEF00D, {1'b0, 32'h0});
    drain();
    send(1'b1, 32'h0010, 1'b0, 4'h0, 32'h0, {1'b0, 32'hCAFEF00D});
    drain();

    // Reset while a response is pending drops it
    d_resp_ready = 1'b0;
    send(1'b1, 32'h10, 1'b0, 4'h0, 32'h0, {1'b0, 32'hCAFEF00D});
    chk_latency(1'b1);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b0;
    exp_d_q.delete();
    d_resp_ready = 1'b1;
    @(negedge clk);
    chk_outputs_zero("rst_resp");

    // Reset in the ACCESS cycle of a store suppresses the write
    send(1'b1, 32'h20, 1'b1, 4'hF, 32'h0, {1'b0, 32'h0});
    drain();
    send(1'b1, 32'h20, 1'b1, 4'hF, 32'h12345678, {1'b0, 32'h0});
    rstn = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b0;
    exp_d_q.delete();
    @(negedge clk);
    chk_outputs_zero("rst_access");
    @(posedge clk); #1;
    send(1'b1, 32'h20, 1'b0, 4'h0, 32'h0, {1'b0, 32'h0});
    drain();

`ifdef MEM_MISALIGN_CHECK_EN
    send(1'b1, 32'h21, 1'b1, 4'hF, 32'hFFFFFFFF, {1'b1, 32'h0});
    drain();
    send(1'b1, 32'h22, 1'b0, 4'h0, 32'h0, {1'b1, 32'h0});
    chk_latency(1'b1);
    drain();
    send(1'b0, 32'h13, 1'b0, 4'h0, 32'h0, {1'b1, 32'h0});
    drain();
    send(1'b1, 32'h20, 1'b0, 4'h0, 32'h0, {1'b0, 32'h0});
    drain();
`else
    send(1'b1, 32'h22, 1'b0, 4'h0, 32'h0, {1'b0, 32'h0});
    drain();
    send(1'b0, 32'h13, 1'b0, 4'h0, 32'h0, {1'b0, 32'hCAFEF00D});
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
